// File: rtl/serial_sort3_if.sv
// -----------------------------------------------------------------------------
// serial_sort3_if
//   Stream bundle for serial_sort3: an input valid/ready stream carrying the
//   words to sort, an output valid/ready stream carrying the sorted triple
//   (with out_last on its final word), and a busy status flag.
//
//   Parameters : W - data width
//   Modports   : master - producer/consumer side (drives in_*, out_ready)
//                slave  - sorter side (drives in_ready, out_*, busy)
// -----------------------------------------------------------------------------
interface serial_sort3_if #(
  parameter int W = 8
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         out_last;
  logic         busy;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last, busy
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last, busy
  );
endinterface

// File: rtl/serial_sort3.sv
// -----------------------------------------------------------------------------
// serial_sort3
//   Streaming three-value sorter. Words arrive one per input handshake and are
//   insertion-sorted into three slots (slot0 <= slot1 <= slot2). After the third
//   word the block emits the triple serially, high-to-low when DESCEND = 1 or
//   low-to-high when DESCEND = 0, then returns to collecting. No overlap between
//   triples: input is refused while emitting.
//
//   Parameters : W       - data width (unsigned compare)
//                DESCEND - 1: emit high, mid, low; 0: emit low, mid, high
//   Ports      : clk     - clock, rising edge
//                rst_n   - asynchronous active-low reset
//                s       - stream bundle (slave modport): in_valid/in_ready/
//                          in_data, out_valid/out_ready/out_data/out_last, busy
// -----------------------------------------------------------------------------
module serial_sort3 #(
  parameter int W       = 8,
  parameter bit DESCEND = 1'b1
) (
  input  logic           clk,
  input  logic           rst_n,
  serial_sort3_if.slave  s
);

  typedef enum logic {
    COLLECT = 1'b0,
    EMIT    = 1'b1
  } state_e;

  state_e       state_q, state_d;
  logic [W-1:0] slot_q [3];
  logic [W-1:0] slot_d [3];
  logic [1:0]   cnt_q, cnt_d;
  logic [1:0]   idx_q, idx_d;

  // gt[i]: slot i is occupied and strictly greater than the incoming word.
  // Occupied slots are ascending, so gt is a contiguous run at the top; those
  // entries shift up by one. Equal entries are not "greater", so a new word
  // lands after any existing equals.
  logic [2:0]   gt;
  logic [1:0]   sel;
  logic         emit;

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      gt[i] = (2'(i) < cnt_q) && (slot_q[i] > s.in_data);
    end
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the case leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    slot_d  = slot_q;

    case (state_q)
      COLLECT: begin
        // in_ready is 1 throughout COLLECT, so in_valid alone is the handshake.
        if (s.in_valid) begin
          if (cnt_q == 2'd0 || gt[0]) slot_d[0] = s.in_data;
          if (cnt_q == 2'd1 || gt[1]) slot_d[1] = gt[0] ? slot_q[0] : s.in_data;
          if (cnt_q == 2'd2)          slot_d[2] = gt[1] ? slot_q[1] : s.in_data;
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd2) begin
            state_d = EMIT;
            idx_d   = 2'd0;
          end
        end
      end
      EMIT: begin
        if (s.out_ready) begin
          if (idx_q == 2'd2) begin
            // Slots are left stale; cnt = 0 marks them all empty.
            state_d = COLLECT;
            cnt_d   = 2'd0;
            idx_d   = 2'd0;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= COLLECT;
      cnt_q   <= 2'd0;
      idx_q   <= 2'd0;
      // NOTE: the slots are a three-entry flop array, not a RAM, so they are
      // reset along with the control state and start from known contents.
      for (int i = 0; i < 3; i++) slot_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      slot_q  <= slot_d;
    end
  end

  // Handshake flags come from state registers only; no combinational path
  // from in_valid or out_ready.
  assign emit       = (state_q == EMIT);
  assign sel        = DESCEND ? (2'd2 - idx_q) : idx_q;
  assign s.in_ready = !emit;
  assign s.out_valid = emit;
  assign s.out_data = emit ? slot_q[sel] : '0;
  assign s.out_last = emit && (idx_q == 2'd2);
  assign s.busy     = emit || (cnt_q != 2'd0);

endmodule

// File: tb/tb_serial_sort3.sv
// -----------------------------------------------------------------------------
// tb_serial_sort3
//   Drives two sorters (DESCEND = 1 and DESCEND = 0) with identical stimulus and
//   checks each against a reference built by sorting every input triple.
// -----------------------------------------------------------------------------
module tb_serial_sort3;
  localparam int W = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  serial_sort3_if #(.W(W)) ifd ();
  serial_sort3_if #(.W(W)) ifa ();

  serial_sort3 #(.W(W), .DESCEND(1'b1)) dut_d (.clk(clk), .rst_n(rst_n), .s(ifd));
  serial_sort3 #(.W(W), .DESCEND(1'b0)) dut_a (.clk(clk), .rst_n(rst_n), .s(ifa));

  task automatic set_in(input logic v, input logic [W-1:0] d, input logic r);
    ifd.in_valid = v; ifd.in_data = d; ifd.out_ready = r;
    ifa.in_valid = v; ifa.in_data = d; ifa.out_ready = r;
  endtask

  // Reset-state view: {in_ready, out_valid, out_last, busy, out_data}.
  task automatic check_reset_values(input string tag);
    checks++;
    if ({ifd.in_ready, ifd.out_valid, ifd.out_last, ifd.busy, ifd.out_data} !== {4'b1000, 8'h00}) begin
      errors++;
      $display("FAIL %s desc: got rdy/vld/last/busy/data=%b%b%b%b/%h want 1000/00", tag,
               ifd.in_ready, ifd.out_valid, ifd.out_last, ifd.busy, ifd.out_data);
    end
    checks++;
    if ({ifa.in_ready, ifa.out_valid, ifa.out_last, ifa.busy, ifa.out_data} !== {4'b1000, 8'h00}) begin
      errors++;
      $display("FAIL %s asc: got rdy/vld/last/busy/data=%b%b%b%b/%h want 1000/00", tag,
               ifa.in_ready, ifa.out_valid, ifa.out_last, ifa.busy, ifa.out_data);
    end
  endtask

  // Runs one triple cycle by cycle. Entered and left just after a rising edge.
  // mode 0: out_ready = 1; mode 1: out_ready low for 4 emit cycles then 1/0
  // toggling; mode 2: random out_ready. gaps = 1 inserts random input bubbles.
  // While the model says the triple is complete, in_valid stays high with junk
  // data, which the sorter must ignore.
  task automatic run_triple(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c,
                            input int mode, input bit gaps, output int period);
    logic [W-1:0] vals [3];
    logic [W-1:0] q [$];
    int acc, out_n, cyc, ecyc;
    logic emit, iv, ordy;
    logic [W-1:0] din;
    vals[0] = a; vals[1] = b; vals[2] = c;
    q.push_back(a); q.push_back(b); q.push_back(c);
    q.sort();
    acc = 0; out_n = 0; cyc = 0; ecyc = 0;
    while (out_n < 3) begin
      if (cyc >= 200) begin
        checks++; errors++;
        $display("FAIL triple_timeout: got %0d outputs after %0d cycles, want 3", out_n, cyc);
        break;
      end
      emit = (acc == 3);
      iv   = emit ? 1'b1 : (gaps ? 1'($urandom) : 1'b1);
      din  = (emit || !iv) ? W'($urandom) : vals[acc];
      case (mode)
        0:       ordy = 1'b1;
        1:       ordy = !emit ? 1'($urandom) : ((ecyc < 4) ? 1'b0 : (((ecyc - 4) % 2) == 0));
        default: ordy = 1'($urandom);
      endcase
      set_in(iv, din, ordy);
      @(negedge clk);
      checks++;
      if ({ifd.in_ready, ifd.out_valid, ifd.busy} !== {!emit, emit, (emit || acc != 0)}) begin
        errors++;
        $display("FAIL flags desc cyc%0d: got rdy/vld/busy=%b%b%b want %b%b%b", cyc,
                 ifd.in_ready, ifd.out_valid, ifd.busy, !emit, emit, (emit || acc != 0));
      end
      checks++;
      if ({ifa.in_ready, ifa.out_valid, ifa.busy} !== {!emit, emit, (emit || acc != 0)}) begin
        errors++;
        $display("FAIL flags asc cyc%0d: got rdy/vld/busy=%b%b%b want %b%b%b", cyc,
                 ifa.in_ready, ifa.out_valid, ifa.busy, !emit, emit, (emit || acc != 0));
      end
      if (emit) begin
        checks++;
        if ({ifd.out_data, ifd.out_last} !== {q[2 - out_n], (out_n == 2)}) begin
          errors++;
          $display("FAIL data desc #%0d: got %h last=%b want %h last=%b", out_n,
                   ifd.out_data, ifd.out_last, q[2 - out_n], (out_n == 2));
        end
        checks++;
        if ({ifa.out_data, ifa.out_last} !== {q[out_n], (out_n == 2)}) begin
          errors++;
          $display("FAIL data asc #%0d: got %h last=%b want %h last=%b", out_n,
                   ifa.out_data, ifa.out_last, q[out_n], (out_n == 2));
        end
        ecyc++;
        if (ordy) out_n++;
      end else if (iv) begin
        acc++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    period = cyc;
  endtask

  task automatic test_reset;
    set_in(1'b0, '0, 1'b0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_values("reset_hold");
    rst_n = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check_reset_values("after_reset");
    @(posedge clk); #1;
  endtask

  task automatic test_basic;
    int p;
    run_triple(8'h30, 8'h10, 8'h20, 0, 1'b0, p);
    checks++;
    if (p !== 6) begin
      errors++;
      $display("FAIL basic_period: got %0d want 6", p);
    end
  endtask

  task automatic test_extremes;
    int p;
    run_triple(8'hFF, 8'h00, 8'hFF, 0, 1'b0, p);
    run_triple(8'h00, 8'h00, 8'h80, 0, 1'b0, p);
    run_triple(8'h7F, 8'h80, 8'h7F, 0, 1'b0, p);
  endtask

  task automatic test_stall;
    int p;
    run_triple(8'd5, 8'd9, 8'd1, 1, 1'b0, p);
    set_in(1'b0, '0, 1'b0);
    @(negedge clk);
    checks++;
    if ({ifd.in_ready, ifa.in_ready} !== 2'b11) begin
      errors++;
      $display("FAIL stall_in_ready_return: got %b%b want 11", ifd.in_ready, ifa.in_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid;
    int p;
    set_in(1'b1, 8'h55, 1'b0);
    @(posedge clk); #1;
    set_in(1'b1, 8'h66, 1'b0);
    @(posedge clk); #1;
    set_in(1'b0, '0, 1'b0);
    @(negedge clk);
    checks++;
    if ({ifd.busy, ifa.busy} !== 2'b11) begin
      errors++;
      $display("FAIL mid_busy_before_reset: got %b%b want 11", ifd.busy, ifa.busy);
    end
    #2 rst_n = 1'b0;
    #1 check_reset_values("async_reset_mid");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_triple(8'd7, 8'd3, 8'd8, 0, 1'b0, p);
  endtask

  task automatic test_back_to_back;
    int p;
    int bad_period;
    bad_period = 0;
    for (int t = 0; t < 1000; t++) begin
      run_triple(W'($urandom), W'($urandom), W'($urandom), 0, 1'b0, p);
      if (p != 6) bad_period++;
    end
    checks++;
    if (bad_period !== 0) begin
      errors++;
      $display("FAIL stream_period: got %0d triples not 6 cycles, want 0", bad_period);
    end
  endtask

  task automatic test_random_flow;
    int p;
    for (int t = 0; t < 200; t++) begin
      // Narrow value range makes duplicates common.
      run_triple(W'($urandom_range(0, 7)), W'($urandom_range(0, 7)), W'($urandom), 2, 1'b1, p);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_extremes();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    test_random_flow();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
